fsm: RTL and testbench

FSM -- requirements
Module: fsm

---
 rtl/fsm.sv | 44 ++++
 tb/tb_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// Moore serial detector for the bit pattern 1,0,1,0,1 with overlapping matches.
// The state register is exported directly and the match flag is decoded from it.
module fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    output logic       z,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } state_t;

    logic [2:0] r_state;
    logic       w_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            case (r_state)
                S0:      r_state <= x ? S1 : S0;
                S1:      r_state <= x ? S1 : S2;
                S2:      r_state <= x ? S3 : S0;
                S3:      r_state <= x ? S1 : S4;
                S4:      r_state <= x ? S5 : S0;
                S5:      r_state <= x ? S1 : S4;
                // 110 and 111 are unreachable; fall back to idle whatever x is
                default: r_state <= S0;
            endcase
        end
    end

    assign w_match = (r_state == S5);
    assign z       = w_match;
    assign state   = r_state;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the 10101 detector: a suffix-matching model checked every
// cycle, plus literal expectations for the reference streams.
module tb_fsm;

    logic       clk;
    logic       rst;
    logic       x;
    logic       z;
    logic [2:0] state;

    int checks;
    int errors;
    bit skip;
    bit mdl_clr;

    logic [4:0] hist;
    int         nbits;

    localparam logic [4:0] PAT = 5'b10101;

    fsm dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .z     (z),
        .state (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the state is the length of the longest suffix of the bits seen
    // since reset that is also a prefix of the pattern.
    always @(posedge clk or negedge rst) begin
        if (!rst || mdl_clr) begin
            hist  = '0;
            nbits = 0;
        end else begin
            hist = {hist[3:0], x};
            if (nbits < 5) nbits++;
        end
    end

    function automatic int exp_state();
        logic [4:0] mask;
        for (int k = 5; k >= 1; k--) begin
            mask = 5'((32'd1 << k) - 1);
            if (nbits >= k && ((hist & mask) == (PAT >> (5 - k))))
                return k;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!skip) begin
            chk("model_state", int'(state), exp_state());
            chk("model_z", int'(z), (exp_state() == 5) ? 1 : 0);
        end
    end

    task automatic step(input logic b);
        x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_state_now", int'(state), 0);
        chk("rst_z_now", int'(z), 0);
        x = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_state_hold", int'(state), 0);
        chk("rst_z_hold", int'(z), 0);
        @(posedge clk);
        #1;
        chk("rst_state_hold2", int'(state), 0);
        rst = 1'b1;
    endtask

    task automatic illegal(input bit hi, input logic b);
        skip    = 1'b1;
        mdl_clr = 1'b1;
        @(negedge clk);
        if (hi) force dut.r_state = 3'b111;
        else    force dut.r_state = 3'b110;
        #1;
        chk("illegal_z", int'(z), 0);
        release dut.r_state;
        x = b;
        @(posedge clk);
        #1;
        chk("illegal_next_state", int'(state), 0);
        chk("illegal_next_z", int'(z), 0);
        mdl_clr = 1'b0;
        skip    = 1'b0;
    endtask

    logic [24:0] ref_stream;
    logic [24:0] ref_z;
    logic [2:0]  ref_st [7];
    logic [6:0]  ovl;
    logic [9:0]  nft;

    initial begin
        checks     = 0;
        errors     = 0;
        skip       = 1'b0;
        mdl_clr    = 1'b0;
        rst        = 1'b0;
        x          = 1'b0;
        ref_stream = 25'b0010101101011100010101100;
        // bit 24 is edge 1; z high after edges 7, 12 and 22
        ref_z      = 25'b0000001000010000000001000;
        ref_st     = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        ovl        = 7'b1010101;
        nft        = 10'b1001011011;

        #2;
        chk("por_state", int'(state), 0);
        chk("por_z", int'(z), 0);
        @(posedge clk);
        #1;
        chk("por_hold_state", int'(state), 0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(ref_stream[24 - i]);
            chk($sformatf("ref_z_e%0d", i + 1), int'(z), int'(ref_z[24 - i]));
            if (i < 7)
                chk($sformatf("ref_state_e%0d", i + 1), int'(state), int'(ref_st[i]));
        end

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(ovl[6 - i]);
            chk($sformatf("ovl_z_e%0d", i + 1), int'(z), (i == 4 || i == 6) ? 1 : 0);
            if (i == 5) chk("ovl_state_e6", int'(state), 4);
        end

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(nft[9 - i]);
            chk($sformatf("nft_z_e%0d", i + 1), int'(z), 0);
        end

        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        chk("mid_state_before", int'(state), 4);
        #2 rst = 1'b0;
        #1;
        chk("mid_state_async", int'(state), 0);
        chk("mid_z_async", int'(z), 0);
        rst = 1'b1;
        step(1'b1);
        chk("mid_state_after", int'(state), 1);
        chk("mid_z_after", int'(z), 0);

        illegal(1'b0, 1'b0);
        illegal(1'b0, 1'b1);
        illegal(1'b1, 1'b0);
        illegal(1'b1, 1'b1);

        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk("post_illegal_match_z", int'(z), 1);
        chk("post_illegal_match_state", int'(state), 5);
        step(1'b1);
        chk("post_match_state", int'(state), 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
